// File: rtl/coord_frame_pkg.sv
// Shared constants, state types and checksum helper for the coordinate-frame
// UART transmitter and its matching receiver.
package coord_frame_pkg;

  localparam logic [7:0]  FRAME_HDR0    = 8'hAA;
  localparam logic [7:0]  FRAME_HDR1    = 8'h55;
  localparam int unsigned FRAME_BYTES   = 15;
  localparam int unsigned PAYLOAD_BYTES = 12;

  typedef enum logic [1:0] {
    F_IDLE,
    F_SEND,
    F_DONE
  } frame_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

  // Mod-256 sum of the payload bytes; byte order does not matter for a sum.
  function automatic logic [7:0] payload_sum(input logic [8*PAYLOAD_BYTES-1:0] p);
    logic [7:0] s;
    s = '0;
    for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
      s = s + p[8*i +: 8];
    end
    return s;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. A start request arriving in the last stop-bit cycle is
// accepted directly, so consecutive bytes leave no idle gap on the line.
module uart_byte_tx
  import coord_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       byte_done
);

  localparam int unsigned      CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  byte_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end   = (cnt == CNT_LAST);
  assign byte_done = (state == B_STOP) && bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= B_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        B_IDLE: begin
          cnt <= '0;
          if (start) begin
            state <= B_START;
            shreg <= data;
            tx    <= 1'b0;
          end
        end
        B_START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= B_DATA;
            tx      <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= B_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (start) begin
              state <= B_START;
              shreg <= data;
              tx    <= 1'b0;
            end else begin
              state <= B_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= B_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/coord_frame_tx.sv
// Coordinate-frame transmitter: captures an x/y/z triple and sends
// AA 55, x, y, z (big-endian) and a payload checksum as 8N1 bytes.
module coord_frame_tx
  import coord_frame_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [3:0]  LAST_IDX     = 4'(FRAME_BYTES - 1);

  frame_state_t state;
  logic [3:0]   idx;
  logic [95:0]  shadow;
  logic [7:0]   csum;
  logic         capture;
  logic         start;
  logic         byte_done;
  logic [7:0]   byte_data;

  function automatic logic [7:0] frame_byte(input logic [3:0] k, input logic [95:0] p,
                                            input logic [7:0] c);
    if (k == 4'd0)                    return FRAME_HDR0;
    else if (k == 4'd1)               return FRAME_HDR1;
    else if (k <= 4'd13)              return p[8*(13 - int'(k)) +: 8];
    else                              return c;
  endfunction

  assign capture = in_valid && in_ready;
  assign csum    = payload_sum(shadow);

  // The first header byte is started on the capture edge itself, and each
  // following byte on the last stop-bit cycle of its predecessor.
  always_comb begin
    start     = 1'b0;
    byte_data = FRAME_HDR0;
    if (capture) begin
      start = 1'b1;
    end else if (state == F_SEND && byte_done && idx != LAST_IDX) begin
      start     = 1'b1;
      byte_data = frame_byte(idx + 4'd1, shadow, csum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= F_IDLE;
      idx      <= '0;
      shadow   <= '0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        F_IDLE, F_DONE: begin
          done <= 1'b0;
          if (capture) begin
            shadow   <= {x, y, z};
            idx      <= '0;
            state    <= F_SEND;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end else begin
            state    <= F_IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        F_SEND: begin
          if (byte_done) begin
            if (idx == LAST_IDX) begin
              state    <= F_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: begin
          state    <= F_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk       (clk),
    .rst       (rst),
    .data      (byte_data),
    .start     (start),
    .tx        (tx),
    .byte_done (byte_done)
  );

endmodule
